// File: rtl/diag_drain_dispatcher_pkg.sv
// lvg_pkg: shared encodings and anti-diagonal geometry helpers for the diagonal drain dispatcher.
// Rev 1.0
`default_nettype none

package lvg_pkg;

   localparam logic [1:0] MODE_PASS      = 2'b00;
   localparam logic [1:0] MODE_ADD       = 2'b01;
   localparam logic [1:0] MODE_PASS_RELU = 2'b10;
   localparam logic [1:0] MODE_ADD_RELU  = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

   // Number of elements on anti-diagonal k: N - |k-(N-1)|.
   function automatic int diag_len(input int k, input int n);
      return (k < n) ? (k + 1) : (2 * n - 1 - k);
   endfunction

   function automatic int diag_row(input int k, input int l, input int n);
      return (k > n - 1) ? (l + k - n + 1) : l;
   endfunction

endpackage

`default_nettype wire

// File: rtl/diag_drain_dispatcher_fpadd.sv
// diag_fpadd: combinational IEEE-754 binary32 adder, round-to-nearest-even, subnormals handled.
// Rev 1.0
`default_nettype none

module diag_fpadd (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   output logic [31:0] sum_o
);

   logic        w_swap, w_eff_sub, w_rup, w_special, w_nan;
   logic [31:0] w_x, w_y;
   logic [7:0]  w_ex, w_ey, w_d;
   logic [26:0] w_mx, w_my0, w_my, w_lost, w_norm;
   logic [27:0] w_sum;
   logic [4:0]  w_lz, w_sh;
   logic [8:0]  w_e, w_eo;
   logic [24:0] w_rnd;
   logic [22:0] w_frac;

   always_comb begin
      // x always carries the larger magnitude, so it also supplies the result sign
      w_swap    = b_i[30:0] > a_i[30:0];
      w_x       = w_swap ? b_i : a_i;
      w_y       = w_swap ? a_i : b_i;
      w_ex      = (w_x[30:23] == 8'd0) ? 8'd1 : w_x[30:23];
      w_ey      = (w_y[30:23] == 8'd0) ? 8'd1 : w_y[30:23];
      w_mx      = {(w_x[30:23] != 8'd0), w_x[22:0], 3'b000};
      w_my0     = {(w_y[30:23] != 8'd0), w_y[22:0], 3'b000};
      w_d       = w_ex - w_ey;
      w_lost    = '0;
      if (w_d >= 8'd27) begin
         w_my = {26'd0, |w_my0};
      end else begin
         w_lost = w_my0 & ((27'd1 << w_d) - 27'd1);
         w_my   = (w_my0 >> w_d) | {26'd0, |w_lost};
      end
      w_eff_sub = w_x[31] ^ w_y[31];
      w_sum     = w_eff_sub ? ({1'b0, w_mx} - {1'b0, w_my}) : ({1'b0, w_mx} + {1'b0, w_my});

      w_lz = 5'd0;
      for (int i = 0; i < 27; i++) begin
         if (w_sum[i]) w_lz = 5'(26 - i);
      end

      w_sh = 5'd0;
      if (w_sum[27]) begin
         w_norm = {w_sum[27:2], w_sum[1] | w_sum[0]};
         w_e    = {1'b0, w_ex} + 9'd1;
      end else begin
         // Left shift stops at the minimum exponent, leaving a subnormal
         w_sh   = ({3'b000, w_lz} < w_ex) ? w_lz : (w_ex[4:0] - 5'd1);
         w_norm = w_sum[26:0] << w_sh;
         w_e    = {1'b0, w_ex} - {4'b0000, w_sh};
      end

      w_rup = w_norm[2] & (w_norm[1] | w_norm[0] | w_norm[3]);
      w_rnd = {1'b0, w_norm[26:3]} + {24'd0, w_rup};
      if (w_rnd[24])      w_eo = w_e + 9'd1;
      else if (w_rnd[23]) w_eo = w_e;
      else                w_eo = 9'd0;
      w_frac = w_rnd[24] ? w_rnd[23:1] : w_rnd[22:0];

      w_special = (w_x[30:23] == 8'hFF) || (w_y[30:23] == 8'hFF);
      w_nan     = ((w_x[30:23] == 8'hFF) && (w_x[22:0] != 23'd0)) ||
                  ((w_y[30:23] == 8'hFF) && (w_y[22:0] != 23'd0)) ||
                  ((w_y[30:23] == 8'hFF) && w_eff_sub);

      if (w_special)          sum_o = w_nan ? 32'h7FC0_0000 : {w_x[31], 8'hFF, 23'd0};
      else if (w_sum == '0)   sum_o = {w_x[31] & w_y[31], 31'd0};
      else if (w_eo >= 9'd255) sum_o = {w_x[31], 8'hFF, 23'd0};
      else                    sum_o = {w_x[31], w_eo[7:0], w_frac};
   end

endmodule

`default_nettype wire

// File: rtl/diag_lane_mux.sv
// diag_lane_mux: routes the R/A elements of anti-diagonal k onto N lanes with a valid mask.
// Rev 1.0
`default_nettype none

module diag_lane_mux
   import lvg_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 32,
   parameter int KW = $clog2(2*N-1)
) (
   input  logic [KW-1:0]    k_i,
   input  logic [N*N*W-1:0] r_flat_i,
   input  logic [N*N*W-1:0] a_flat_i,
   output logic [N*W-1:0]   r_lane_o,
   output logic [N*W-1:0]   a_lane_o,
   output logic [N-1:0]     vld_o
);

   always_comb begin
      r_lane_o = '0;
      a_lane_o = '0;
      vld_o    = '0;
      for (int l = 0; l < N; l++) begin
         if (l < diag_len(int'(k_i), N)) begin
            // Flat index row*N + (k-row) simplifies to row*(N-1) + k
            vld_o[l]             = 1'b1;
            r_lane_o[l*W +: W]   = r_flat_i[(diag_row(int'(k_i), l, N)*(N-1) + int'(k_i))*W +: W];
            a_lane_o[l*W +: W]   = a_flat_i[(diag_row(int'(k_i), l, N)*(N-1) + int'(k_i))*W +: W];
         end
      end
   end

endmodule

`default_nettype wire

// File: rtl/diag_drain_dispatcher.sv
// diag_drain_dispatcher: drains an NxN result matrix one anti-diagonal per beat, optional fp32 add / ReLU.
// Rev 1.0
`default_nettype none

module diag_drain_dispatcher
   import lvg_pkg::*;
#(
   parameter int N  = 4,
   parameter int W  = 32,
   parameter int KW = $clog2(2*N-1)
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [1:0]       mode,
   input  logic [N*N*W-1:0] r_flat,
   input  logic [N*N*W-1:0] a_flat,
   output logic [N*W-1:0]   d_flat,
   output logic [N-1:0]     lane_vld,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_last,
   output logic [KW-1:0]    diag_idx,
   output logic             busy,
   output logic             done
);

   localparam logic [KW-1:0] K_LAST = KW'(2*N-2);

   state_t          state_q;
   logic [KW-1:0]   k_q, idx_q;
   logic [1:0]      mode_q, w_mode;
   logic [N*W-1:0]  d_q, w_r_lane, w_a_lane, w_sum, w_beat;
   logic [N-1:0]    vld_q, w_vld;
   logic            valid_q, last_q, done_q, w_add, w_relu;

   diag_lane_mux #(.N(N), .W(W), .KW(KW)) u_mux (
      .k_i      (k_q),
      .r_flat_i (r_flat),
      .a_flat_i (a_flat),
      .r_lane_o (w_r_lane),
      .a_lane_o (w_a_lane),
      .vld_o    (w_vld)
   );

   if (W == 32) begin : g_fp
      for (genvar l = 0; l < N; l++) begin : g_lane
         diag_fpadd u_add (
            .a_i   (w_r_lane[l*W +: W]),
            .b_i   (w_a_lane[l*W +: W]),
            .sum_o (w_sum[l*W +: W])
         );
      end
   end else begin : g_nofp
      // mode is a run-time input, so any non-fp32 width could be asked to ADD
      $error("diag_drain_dispatcher: W must be 32 for the ADD modes");
      assign w_sum = w_r_lane;
   end

   // The diag-0 beat is formed in the accept cycle, before mode_q holds the new mode
   assign w_mode = (state_q == ST_IDLE) ? mode : mode_q;
   assign w_add  = (w_mode == MODE_ADD) || (w_mode == MODE_ADD_RELU);
   assign w_relu = (w_mode == MODE_PASS_RELU) || (w_mode == MODE_ADD_RELU);

   always_comb begin
      w_beat = '0;
      for (int l = 0; l < N; l++) begin
         if (w_vld[l]) begin
            w_beat[l*W +: W] = w_add ? w_sum[l*W +: W] : w_r_lane[l*W +: W];
            if (w_relu && w_beat[l*W + W - 1]) w_beat[l*W +: W] = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         k_q     <= '0;
         mode_q  <= MODE_PASS;
         d_q     <= '0;
         vld_q   <= '0;
         valid_q <= 1'b0;
         last_q  <= 1'b0;
         idx_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            ST_IDLE, ST_RUN: begin
               if ((state_q == ST_IDLE && start) || (state_q == ST_RUN && (!valid_q || out_ready))) begin
                  d_q     <= w_beat;
                  vld_q   <= w_vld;
                  valid_q <= 1'b1;
                  idx_q   <= k_q;
                  last_q  <= (k_q == K_LAST);
                  if (state_q == ST_IDLE) mode_q <= mode;
                  if (k_q == K_LAST) begin
                     k_q     <= '0;
                     state_q <= ST_DRAIN;
                  end else begin
                     k_q     <= k_q + 1'b1;
                     state_q <= ST_RUN;
                  end
               end
            end
            ST_DRAIN: begin
               if (valid_q && out_ready) begin
                  d_q     <= '0;
                  vld_q   <= '0;
                  valid_q <= 1'b0;
                  last_q  <= 1'b0;
                  idx_q   <= '0;
                  done_q  <= 1'b1;
                  state_q <= ST_IDLE;
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign d_flat    = d_q;
   assign lane_vld  = vld_q;
   assign out_valid = valid_q;
   assign out_last  = last_q;
   assign diag_idx  = idx_q;
   assign busy      = (state_q != ST_IDLE);
   assign done      = done_q;

endmodule

`default_nettype wire
